// File: rtl/chord_sequencer.sv
// chord_sequencer: walks a chord-word song ROM and hands each unpacked chord to the player
// with a one-cycle load strobe, advancing on player done, with pause, song change and end-of-song.
module chord_sequencer #(
    parameter int SONG_SEL_W  = 2,
    parameter int SONG_ADDR_W = 5,
    parameter int ROM_W       = 36
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              play,
    input  logic [SONG_SEL_W-1:0]             song,
    output logic [SONG_SEL_W+SONG_ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]                  rom_data,
    input  logic                              done_with_note,
    output logic [5:0]                        note1,
    output logic [5:0]                        note2,
    output logic [5:0]                        note3,
    output logic [5:0]                        note4,
    output logic [5:0]                        duration,
    output logic [1:0]                        num_notes,
    output logic [2:0]                        metadata,
    output logic                              load_new_note,
    output logic                              song_done
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, LOAD, GUARD, PLAY, DONE} state_t;
    state_t state, state_nxt;
    logic [SONG_SEL_W-1:0]  song_q;
    logic [SONG_ADDR_W-1:0] idx;
    logic chg, last, inc, ld;
    logic [1:0] nn_f;
    assign chg  = song != song_q;
    assign last = &idx;
    assign nn_f = rom_data[31:30];
    // IDLE is only ever entered with index 0, so the live song select can drive the address there
    assign rom_addr      = {(state == IDLE) ? song : song_q, idx};
    assign load_new_note = (state == LOAD) && !chg;
    assign song_done     = state == DONE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        inc = 1'b0;
        ld = 1'b0;
        if (chg) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:     state_nxt = play ? FETCH : IDLE;
                FETCH:    state_nxt = play ? WAIT_ROM : FETCH;
                WAIT_ROM: begin
                    if (play) begin
                        if (rom_data[35]) state_nxt = DONE;
                        else if (rom_data[29:24] == 6'd0) begin
                            inc = !last;
                            state_nxt = last ? DONE : FETCH;
                        end else begin
                            ld = 1'b1;
                            state_nxt = LOAD;
                        end
                    end
                end
                LOAD:     state_nxt = GUARD;
                GUARD:    state_nxt = PLAY;
                PLAY: begin
                    if (play && done_with_note) begin
                        inc = !last;
                        state_nxt = last ? DONE : FETCH;
                    end
                end
                DONE:     state_nxt = DONE;
                default:  state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            song_q    <= '0;
            idx       <= '0;
            note1     <= '0;
            note2     <= '0;
            note3     <= '0;
            note4     <= '0;
            duration  <= '0;
            num_notes <= '0;
            metadata  <= '0;
        end else if (chg) begin
            song_q <= song;
            idx    <= '0;
        end else begin
            if (inc) idx <= idx + SONG_ADDR_W'(1);
            if (ld) begin
                note1     <= rom_data[5:0];
                note2     <= (nn_f != 2'd0) ? rom_data[11:6] : 6'd0;
                note3     <= nn_f[1] ? rom_data[17:12] : 6'd0;
                note4     <= (&nn_f) ? rom_data[23:18] : 6'd0;
                duration  <= rom_data[29:24];
                num_notes <= nn_f;
                metadata  <= rom_data[34:32];
            end
        end
    end
endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer: directed stimulus against a song ROM model, with a scoreboard of expected
// chord loads derived from the word layout and voice-masking rule.
module tb_chord_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic [6:0]  rom_addr;
    logic [35:0] rom_data = '0;
    logic        done_with_note = 1'b0;
    logic [5:0]  note1, note2, note3, note4, duration;
    logic [1:0]  num_notes;
    logic [2:0]  metadata;
    logic        load_new_note, song_done;
    int checks = 0;
    int fails = 0;
    logic [35:0] rom [0:127];
    logic [34:0] exp_q [$];
    logic        prev_load = 1'b0;

    chord_sequencer dut (
        .clk(clk), .reset_n(reset_n), .play(play), .song(song), .rom_addr(rom_addr),
        .rom_data(rom_data), .done_with_note(done_with_note), .note1(note1), .note2(note2),
        .note3(note3), .note4(note4), .duration(duration), .num_notes(num_notes),
        .metadata(metadata), .load_new_note(load_new_note), .song_done(song_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [35:0] mk(input logic e, input logic [2:0] m, input logic [1:0] nn,
                                       input logic [5:0] d, input logic [5:0] n4, input logic [5:0] n3,
                                       input logic [5:0] n2, input logic [5:0] n1);
        return {e, m, nn, d, n4, n3, n2, n1};
    endfunction

    // expected player-facing view of a word: voices beyond the voice count read as rests
    function automatic logic [34:0] exp_out(input logic [35:0] w);
        logic [5:0] n [4];
        for (int v = 0; v < 4; v++) n[v] = (v <= int'(w[31:30])) ? w[v*6 +: 6] : 6'd0;
        return {w[34:32], w[31:30], w[29:24], n[3], n[2], n[1], n[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_new_note && n < 200);
        chk("strobe_seen", {63'd0, load_new_note}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (reset_n && load_new_note) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
            else chk("chord_fields", {29'd0, metadata, num_notes, duration, note4, note3, note2, note1},
                     {29'd0, exp_q.pop_front()});
            if (prev_load) chk("strobe_width", 64'd2, 64'd1);
        end
        prev_load <= load_new_note;
    end

    initial begin
        int n;
        logic [34:0] m;
        for (int i = 0; i < 128; i++) rom[i] = mk(1'b1, 3'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        rom[0] = mk(1'b0, 3'd5, 2'd3, 6'd12, 6'd4, 6'd3, 6'd2, 6'd1);
        rom[1] = mk(1'b0, 3'd2, 2'd1, 6'd8, 6'd9, 6'd8, 6'd7, 6'd6);
        rom[2] = mk(1'b0, 3'd6, 2'd3, 6'd0, 6'd50, 6'd51, 6'd52, 6'd53);
        rom[3] = mk(1'b0, 3'd3, 2'd2, 6'd5, 6'd20, 6'd21, 6'd22, 6'd23);
        for (int i = 32; i < 63; i++) rom[i] = mk(1'b0, 3'd1, 2'd3, 6'd0, 6'd1, 6'd1, 6'd1, 6'd1);
        rom[63] = mk(1'b0, 3'd4, 2'd0, 6'd17, 6'd40, 6'd41, 6'd42, 6'd43);
        rom[64] = mk(1'b0, 3'd1, 2'd0, 6'd3, 6'd10, 6'd11, 6'd12, 6'd33);
        rom[65] = mk(1'b0, 3'd7, 2'd3, 6'd40, 6'd1, 6'd2, 6'd3, 6'd4);
        m = exp_out(rom[0]);
        chk("model_w0", {29'd0, m}, {29'd0, 3'd5, 2'd3, 6'd12, 6'd4, 6'd3, 6'd2, 6'd1});
        m = exp_out(rom[1]);
        chk("model_w1", {29'd0, m}, {29'd0, 3'd2, 2'd1, 6'd8, 6'd0, 6'd0, 6'd7, 6'd6});
        song = 2'd2;
        repeat (2) @(negedge clk);
        chk("rst_addr_song2", {57'd0, rom_addr}, 64'd64);
        song = 2'd0;
        @(negedge clk);
        chk("rst_addr", {57'd0, rom_addr}, 64'd0);
        chk("rst_notes", {40'd0, note4, note3, note2, note1}, 64'd0);
        chk("rst_flags", {62'd0, load_new_note, song_done}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        play = 1'b1;
        exp_q.push_back(exp_out(rom[0]));
        wait_strobe(n);
        chk("fetch_to_load", n, 3);
        chk("w0_note1", note1, 1);
        chk("w0_note4", note4, 4);
        chk("w0_dur_nn_meta", {duration, num_notes, metadata}, {6'd12, 2'd3, 3'd5});
        done_with_note = 1'b1;
        exp_q.push_back(exp_out(rom[1]));
        wait_strobe(n);
        chk("done_held_latency", n, 5);
        chk("w1_notes", {note4, note3, note2, note1}, {6'd0, 6'd0, 6'd7, 6'd6});
        done_with_note = 1'b0;
        repeat (2) @(negedge clk);
        done_with_note = 1'b1;
        exp_q.push_back(exp_out(rom[3]));
        @(negedge clk);
        done_with_note = 1'b0;
        chk("addr_idx2", {57'd0, rom_addr}, 64'd2);
        repeat (2) @(negedge clk);
        chk("addr_idx3", {57'd0, rom_addr}, 64'd3);
        wait_strobe(n);
        chk("skip_latency", n, 2);
        chk("w3_notes", {note4, note3, note2, note1}, {6'd0, 6'd21, 6'd22, 6'd23});
        done_with_note = 1'b1;
        repeat (4) @(negedge clk);
        chk("eos_not_yet", {63'd0, song_done}, 0);
        @(negedge clk);
        chk("eos_done", {63'd0, song_done}, 1);
        repeat (6) @(negedge clk);
        chk("done_hold", {56'd0, song_done, rom_addr}, {56'd0, 1'b1, 7'd4});
        song = 2'd2;
        @(negedge clk);
        done_with_note = 1'b0;
        chk("chg_done_clear", {63'd0, song_done}, 0);
        chk("chg_addr", {57'd0, rom_addr}, 64'd64);
        chk("chg_notes_hold", {40'd0, note4, note3, note2, note1}, {40'd0, 6'd0, 6'd21, 6'd22, 6'd23});
        exp_q.push_back(exp_out(rom[64]));
        wait_strobe(n);
        chk("chg_latency", n, 3);
        chk("s2w0_notes", {note4, note3, note2, note1}, {6'd0, 6'd0, 6'd0, 6'd33});
        repeat (2) @(negedge clk);
        play = 1'b0;
        done_with_note = 1'b1;
        repeat (5) @(negedge clk);
        chk("pause_addr", {57'd0, rom_addr}, 64'd64);
        chk("pause_no_strobe", {63'd0, load_new_note}, 0);
        play = 1'b1;
        exp_q.push_back(exp_out(rom[65]));
        wait_strobe(n);
        chk("resume_latency", n, 3);
        repeat (3) @(negedge clk);
        chk("addr_s2_idx2", {57'd0, rom_addr}, 64'd66);
        @(negedge clk);
        reset_n = 1'b0;
        play = 1'b0;
        #1;
        chk("midrst_notes", {40'd0, note4, note3, note2, note1}, 64'd0);
        chk("midrst_fields", {53'd0, duration, num_notes, metadata}, 64'd0);
        chk("midrst_addr_flags", {55'd0, load_new_note, song_done, rom_addr}, 64'd64);
        @(negedge clk);
        song = 2'd1;
        reset_n = 1'b1;
        play = 1'b1;
        done_with_note = 1'b0;
        exp_q.push_back(exp_out(rom[63]));
        wait_strobe(n);
        chk("last_word_addr", {57'd0, rom_addr}, 64'd63);
        chk("last_word_note1", note1, 43);
        repeat (2) @(negedge clk);
        done_with_note = 1'b1;
        @(negedge clk);
        chk("nowrap_done", {56'd0, song_done, rom_addr}, {56'd0, 1'b1, 7'd63});
        repeat (4) @(negedge clk);
        chk("nowrap_hold", {56'd0, song_done, rom_addr}, {56'd0, 1'b1, 7'd63});
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
